// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmit framer.
// Parity-mode and FSM encodings, FIFO entry width and the parity-bit rule.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  // FIFO entry = data word plus {par_enable, par_mode[1:0], stop2}
  function automatic int unsigned entry_width(input int unsigned width);
    return width + 4;
  endfunction

  function automatic logic parity_bit(input par_mode_t mode, input logic xor_red);
    case (mode)
      PAR_EVEN: return xor_red;
      PAR_ODD:  return ~xor_red;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read data and registered flags.
// Flags are decoded from the next occupancy count so they switch on the push/pop edge.
module uart_tx_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;

  // A push against a full FIFO is dropped even if a pop frees a slot this cycle
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full    <= (count_d == CW'(DEPTH));
      empty   <= (count_d == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: buffers tagged words and serialises one bit per CLK.
// Each frame: start, WIDTH data bits LSB first, optional parity, one or two stops.
module uart_tx_framer
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_ENABLE,
  input  logic [1:0]       PAR_MODE,
  input  logic             STOP2,
  output logic             TX_OUT,
  output logic             BUSY,
  output logic             FULL,
  output logic             EMPTY,
  output logic             PAR_BIT
);

  localparam int unsigned EW  = entry_width(WIDTH);
  localparam int unsigned BCW = $clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic             cfg_par_en_q;
  logic             cfg_stop2_q;
  logic             pop_c;
  logic             tx_d;
  logic             busy_d;

  logic [EW-1:0]    fifo_wdata;
  logic [EW-1:0]    fifo_rdata;
  logic [WIDTH-1:0] rd_data;
  logic             rd_par_en;
  par_mode_t        rd_mode;
  logic             rd_stop2;

  assign fifo_wdata = {P_DATA, PAR_ENABLE, PAR_MODE, STOP2};
  assign rd_data    = fifo_rdata[EW-1 -: WIDTH];
  assign rd_par_en  = fifo_rdata[3];
  assign rd_mode    = par_mode_t'(fifo_rdata[2:1]);
  assign rd_stop2   = fifo_rdata[0];

  uart_tx_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (DATA_VALID),
    .pop   (pop_c),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (FULL),
    .empty (EMPTY)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and pop; the final stop state chains straight into the next start bit
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!EMPTY) begin
          pop_c   = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START:  state_d = ST_DATA;
      ST_DATA: begin
        if (bit_cnt_q == BCW'(WIDTH - 1)) begin
          state_d = cfg_par_en_q ? ST_PARITY : ST_STOP1;
        end
      end
      ST_PARITY: state_d = ST_STOP1;
      ST_STOP1: begin
        if (cfg_stop2_q) begin
          state_d = ST_STOP2;
        end else if (!EMPTY) begin
          pop_c   = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STOP2: begin
        if (!EMPTY) begin
          pop_c   = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Line level and busy for the current state; registered below
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != ST_IDLE);
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_q[0];
      ST_PARITY: tx_d = PAR_BIT;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TX_OUT <= 1'b1;
      BUSY   <= 1'b0;
    end else begin
      TX_OUT <= tx_d;
      BUSY   <= busy_d;
    end
  end

  // Shift register, bit counter and per-frame config captured on pop
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      cfg_par_en_q <= 1'b0;
      cfg_stop2_q  <= 1'b0;
      PAR_BIT      <= 1'b0;
    end else begin
      if (pop_c) begin
        shreg_q      <= rd_data;
        cfg_par_en_q <= rd_par_en;
        cfg_stop2_q  <= rd_stop2;
        PAR_BIT      <= parity_bit(rd_mode, ^rd_data);
      end else if (state_q == ST_DATA) begin
        shreg_q   <= {1'b0, shreg_q[WIDTH-1:1]};
        bit_cnt_q <= bit_cnt_q + BCW'(1);
      end
      if (state_q == ST_START) bit_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer (WIDTH=8, DEPTH=4).
// Inputs change and outputs are sampled on the falling edge of CLK.
module tb_uart_tx_framer;
  import uart_tx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ENABLE;
  logic [1:0] PAR_MODE;
  logic       STOP2;
  logic       TX_OUT;
  logic       BUSY;
  logic       FULL;
  logic       EMPTY;
  logic       PAR_BIT;

  int vec  = 0;
  int miss = 0;

  logic txlog    [64];
  logic emptylog [64];
  logic busylog  [64];

  always #5 CLK = ~CLK;

  uart_tx_framer #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ENABLE (PAR_ENABLE),
    .PAR_MODE   (PAR_MODE),
    .STOP2      (STOP2),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .PAR_BIT    (PAR_BIT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; the push happens on the following rising edge
  task automatic push_word(input logic [7:0] d, input logic pe, input logic [1:0] mode,
                           input logic s2);
    P_DATA     = d;
    PAR_ENABLE = pe;
    PAR_MODE   = mode;
    STOP2      = s2;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  // Starts one cycle after the push edge; bits[i] is the i-th bit on the line
  task automatic check_frame(input string tag, input logic [15:0] bits, input int n,
                             input logic par);
    logic [15:0] obs;
    logic        busy_all;
    obs      = '0;
    busy_all = 1'b1;
    @(negedge CLK);
    chk({tag, "_lead"}, {TX_OUT, BUSY}, 2'b10);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      obs[i] = TX_OUT;
      if (!BUSY) busy_all = 1'b0;
    end
    chk({tag, "_bits"}, obs, bits);
    chk({tag, "_busy"}, busy_all, 1'b1);
    @(negedge CLK);
    chk({tag, "_idle"}, {TX_OUT, BUSY, EMPTY}, 3'b101);
    chk({tag, "_par"}, PAR_BIT, par);
  endtask

  initial begin
    logic [10:0] fobs;
    logic        ovf_busy;
    logic        line_idle;
    logic [4:0]  ovf_par;

    RST        = 1'b1;
    DATA_VALID = 1'b0;
    P_DATA     = '0;
    PAR_ENABLE = 1'b0;
    PAR_MODE   = 2'b00;
    STOP2      = 1'b0;

    // Reset held with random traffic on the inputs
    repeat (4) begin
      @(negedge CLK);
      P_DATA     = 8'($urandom);
      DATA_VALID = 1'b1;
      PAR_ENABLE = 1'($urandom);
      PAR_MODE   = 2'($urandom);
      STOP2      = 1'($urandom);
    end
    @(negedge CLK);
    chk("reset", {TX_OUT, BUSY, FULL, EMPTY, PAR_BIT}, 5'b10010);
    DATA_VALID = 1'b0;
    RST        = 1'b0;
    repeat (3) @(negedge CLK);
    chk("post_reset_idle", {TX_OUT, BUSY, EMPTY}, 3'b101);

    // Single frame 0xA5, even parity, one stop
    push_word(8'hA5, 1'b1, PAR_EVEN, 1'b0);
    chk("a5_empty_fall", EMPTY, 1'b0);
    check_frame("a5", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b0);

    // Parity modes on 0x01 with two stop bits
    push_word(8'h01, 1'b1, PAR_ODD, 1'b1);
    check_frame("odd", {2'b11, 1'b0, 8'h01, 1'b0}, 12, 1'b0);
    push_word(8'h01, 1'b1, PAR_MARK, 1'b1);
    check_frame("mark", {2'b11, 1'b1, 8'h01, 1'b0}, 12, 1'b1);
    push_word(8'h01, 1'b1, PAR_SPACE, 1'b1);
    check_frame("space", {2'b11, 1'b0, 8'h01, 1'b0}, 12, 1'b0);
    push_word(8'h01, 1'b1, PAR_EVEN, 1'b1);
    check_frame("even", {2'b11, 1'b1, 8'h01, 1'b0}, 12, 1'b1);

    // No parity slot
    push_word(8'hFF, 1'b0, PAR_EVEN, 1'b0);
    check_frame("nopar", {1'b1, 8'hFF, 1'b0}, 10, 1'b0);

    // Overflow and back-to-back: six pushes, 0x16 dropped
    DATA_VALID = 1'b1;
    PAR_ENABLE = 1'b1;
    PAR_MODE   = PAR_EVEN;
    STOP2      = 1'b0;
    for (int k = 0; k < 6; k++) begin
      P_DATA = 8'(8'h11 + k);
      @(negedge CLK);
      txlog[k]    = TX_OUT;
      emptylog[k] = EMPTY;
      busylog[k]  = BUSY;
      chk($sformatf("ovf_full_%0d", k), FULL, (k >= 4) ? 1'b1 : 1'b0);
    end
    DATA_VALID = 1'b0;
    for (int k = 6; k < 60; k++) begin
      @(negedge CLK);
      txlog[k]    = TX_OUT;
      emptylog[k] = EMPTY;
      busylog[k]  = BUSY;
    end
    chk("ovf_lead", {txlog[0], txlog[1]}, 2'b11);
    chk("ovf_busy_rise", {busylog[1], busylog[2]}, 2'b01);
    ovf_par  = 5'b10100;
    ovf_busy = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 11; i++) begin
        fobs[i] = txlog[2 + 11 * f + i];
        if (!busylog[2 + 11 * f + i]) ovf_busy = 1'b0;
      end
      chk($sformatf("ovf_frame_%0d", f), fobs,
          {1'b1, ovf_par[f], 8'(8'h11 + f), 1'b0});
    end
    chk("ovf_busy_contig", ovf_busy, 1'b1);
    chk("ovf_empty_rise", {emptylog[44], emptylog[45]}, 2'b01);
    chk("ovf_tail", {txlog[57], busylog[57]}, 2'b10);

    // Reset during data bit 3 with two words buffered
    push_word(8'h00, 1'b1, PAR_EVEN, 1'b0);
    push_word(8'h00, 1'b1, PAR_EVEN, 1'b0);
    push_word(8'h00, 1'b1, PAR_EVEN, 1'b0);
    repeat (4) @(negedge CLK);
    chk("mid_pre", {TX_OUT, BUSY, EMPTY}, 3'b010);
    RST = 1'b1;
    #1;
    chk("mid_abort", {TX_OUT, BUSY, EMPTY, FULL}, 4'b1010);
    DATA_VALID = 1'b1;
    P_DATA     = 8'h5A;
    repeat (2) @(negedge CLK);
    chk("mid_hold", {EMPTY, TX_OUT}, 2'b11);
    DATA_VALID = 1'b0;
    RST        = 1'b0;
    line_idle  = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (!TX_OUT || BUSY || !EMPTY) line_idle = 1'b0;
    end
    chk("mid_stay_idle", line_idle, 1'b1);

    // Recovery frame: 0x3C odd parity, two stops
    push_word(8'h3C, 1'b1, PAR_ODD, 1'b1);
    check_frame("recover", {2'b11, 1'b1, 8'h3C, 1'b0}, 12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
